// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide beside the ALU.
// Radix-2 shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [4:0]       ALUCtrl,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int         W2   = 2 * WIDTH;
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MUL    = 5'b01101;
    localparam logic [4:0] OP_MULHSU = 5'b01110;
    localparam logic [4:0] OP_MULHU  = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;
    localparam logic [4:0] OP_DIVU   = 5'b10001;
    localparam logic [4:0] OP_REM    = 5'b10010;
    localparam logic [4:0] OP_REMU   = 5'b10011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             op_valid;
    logic             sgn1, sgn2;
    logic             neg1, neg2;
    logic             in_div;
    logic [WIDTH-1:0] mag1, mag2;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh, rem_df;
    logic [W2-1:0]    step_acc;
    logic [WIDTH-1:0] step_a;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rmd;
    logic [WIDTH-1:0] final_res;

    // decode incoming op: signedness, magnitudes, special divide cases
    always_comb begin
        op_valid = 1'b1;
        sgn1     = 1'b0;
        sgn2     = 1'b0;
        case (ALUCtrl)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                sgn1 = 1'b1;
                sgn2 = 1'b1;
            end
            OP_MULHSU:                 sgn1 = 1'b1;
            OP_MULHU, OP_DIVU, OP_REMU: ;
            default:                   op_valid = 1'b0;
        endcase
        in_div   = ALUCtrl[4];
        neg1     = sgn1 & op1[WIDTH-1];
        neg2     = sgn2 & op2[WIDTH-1];
        mag1     = neg1 ? -op1 : op1;
        mag2     = neg2 ? -op2 : op2;
        div_zero = in_div && (op2 == '0);
        div_ovf  = in_div && sgn1
                   && (op1 == {1'b1, {(WIDTH-1){1'b0}}})
                   && (op2 == '1);
        if (div_zero) begin
            special_res = ALUCtrl[1] ? op1 : '1;
        end else begin
            special_res = ALUCtrl[1] ? '0 : op1;
        end
    end

    // one multiply or divide step, plus sign fix-up of the final value
    always_comb begin
        mul_sum = {1'b0, acc_q[W2-1:WIDTH]}
                + {1'b0, b_q & {WIDTH{a_q[0]}}};
        rem_sh  = {acc_q[W2-1:WIDTH], a_q[WIDTH-1]};
        rem_df  = rem_sh - {1'b0, b_q};
        if (op_q[4]) begin
            if (!rem_df[WIDTH]) begin
                step_acc = {rem_df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            step_a = a_q << 1;
        end else begin
            step_acc = {mul_sum, acc_q[WIDTH-1:1]};
            step_a   = a_q >> 1;
        end
        prod = neg_q ? -step_acc : step_acc;
        quo  = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rmd  = rneg_q ? -step_acc[W2-1:WIDTH] : step_acc[W2-1:WIDTH];
        if (op_q[4]) begin
            final_res = op_q[1] ? rmd : quo;
        end else if (op_q == OP_MUL) begin
            final_res = prod[WIDTH-1:0];
        end else begin
            final_res = prod[W2-1:WIDTH];
        end
    end

    // next-state: iterate in CALC, accept from IDLE/DONE, kill wins
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        case (state_q)
            CALC: begin
                acc_d = step_acc;
                a_d   = step_a;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    res_d   = final_res;
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (start && op_valid && state_q != CALC) begin
            op_d   = ALUCtrl;
            acc_d  = '0;
            cnt_d  = '0;
            neg_d  = neg1 ^ neg2;
            rneg_d = neg1;
            a_d    = in_div ? mag1 : mag2;
            b_d    = in_div ? mag2 : mag1;
            if (div_zero || div_ovf) begin
                state_d = DONE;
                res_d   = special_res;
            end else begin
                state_d = CALC;
            end
        end
        if (kill) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of the iterative mul/div unit.
// Inputs driven and outputs sampled on the falling edge.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        kill;
    logic [4:0]  ALUCtrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .ALUCtrl (ALUCtrl),
        .op1     (op1),
        .op2     (op2),
        .kill    (kill),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // issue one op at the current falling edge, wait for done
    task automatic run(input string tag, input logic [4:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
        int   lat;
        logic seen_busy;
        logic overlap;
        ALUCtrl = c;
        op1     = a;
        op2     = b;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        op1       = $urandom;
        op2       = $urandom;
        lat       = 0;
        seen_busy = 1'b0;
        overlap   = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) seen_busy = 1'b1;
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " result"}, result, exp_res);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy seen"}, {31'b0, seen_busy},
            {31'b0, exp_lat != 1});
        chk({tag, " busy&done"}, {31'b0, overlap}, 32'd0);
    endtask

    initial begin
        logic seen_done;
        resetn  = 1'b0;
        start   = 1'b0;
        kill    = 1'b0;
        ALUCtrl = 5'b0;
        op1     = '0;
        op2     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        run("MULH -1*-1", 5'b01100, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000000, 33);
        @(negedge clk);
        chk("done one cycle", {31'b0, done}, 32'd0);
        run("MULHU ff*ff", 5'b01111, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 33);
        @(negedge clk);
        run("MUL -1*-1", 5'b01101, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000001, 33);
        @(negedge clk);
        run("DIV -7/2", 5'b10000, 32'hFFFFFFF9, 32'h2,
            32'hFFFFFFFD, 33);
        @(negedge clk);
        run("REM -7/2", 5'b10010, 32'hFFFFFFF9, 32'h2,
            32'hFFFFFFFF, 33);
        @(negedge clk);
        run("DIVU big/2", 5'b10001, 32'hFFFFFFF9, 32'h2,
            32'h7FFFFFFC, 33);
        @(negedge clk);
        run("DIVU 5/0", 5'b10001, 32'h5, 32'h0, 32'hFFFFFFFF, 1);
        @(negedge clk);
        run("REMU 5/0", 5'b10011, 32'h5, 32'h0, 32'h00000005, 1);
        @(negedge clk);
        run("DIV ovf", 5'b10000, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 1);
        @(negedge clk);
        run("REM ovf", 5'b10010, 32'h80000000, 32'hFFFFFFFF,
            32'h00000000, 1);
        @(negedge clk);
        run("MULHSU -1*ff", 5'b01110, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 33);
        run("MUL b2b 3*4", 5'b01101, 32'h3, 32'h4, 32'h0000000C, 33);
        @(negedge clk);

        ALUCtrl = 5'b00001;
        op1     = 32'h7;
        op2     = 32'h9;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ADD ignored busy", {31'b0, busy}, 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("ADD ignored done", {31'b0, seen_done}, 32'd0);
        chk("ADD ignored result", result, 32'h0000000C);

        ALUCtrl = 5'b01111;
        op1     = 32'hFFFFFFFF;
        op2     = 32'hFFFFFFFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("kill pre busy", {31'b0, busy}, 32'd1);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill busy", {31'b0, busy}, 32'd0);
        chk("kill done", {31'b0, done}, 32'd0);
        chk("kill result", result, 32'h0000000C);
        seen_done = 1'b0;
        repeat (40) begin
            if (done || busy) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("kill no done later", {31'b0, seen_done}, 32'd0);

        ALUCtrl = 5'b01101;
        op1     = 32'h3;
        op2     = 32'h5;
        start   = 1'b1;
        kill    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        kill  = 1'b0;
        chk("kill+start busy", {31'b0, busy}, 32'd0);
        chk("kill+start done", {31'b0, done}, 32'd0);
        chk("kill+start result", result, 32'h0000000C);

        ALUCtrl = 5'b10000;
        op1     = 32'hFFFFFFF9;
        op2     = 32'h2;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre-reset busy", {31'b0, busy}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("midop reset result", result, 32'h0);
        chk("midop reset busy", {31'b0, busy}, 32'd0);
        chk("midop reset done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("post-reset idle", {31'b0, busy | done}, 32'd0);

        run("REMU after reset", 5'b10011, 32'h5, 32'h0,
            32'h00000005, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
